// File: rtl/accuracy_monitor.sv
// Running classification-accuracy statistics for the DNN output layer: sliding window, epoch and total counts.
// Build with ACC_MON_ARGMAX_EN defined to score by argmax of act_in_i instead of a bitwise a_out_i/y_ideal_i compare.
module accuracy_monitor #(
  parameter int unsigned N_OUT     = 16,
  parameter int unsigned N_CLASS   = 10,
  parameter int unsigned WINDOW    = 1000,
  parameter int unsigned EPOCH_LEN = 10000,
  parameter int unsigned TOTAL     = 100000,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WIDTH     = 10
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         case_valid_i,
  input  logic [N_OUT-1:0]             a_out_i,
  input  logic [N_OUT-1:0]             y_ideal_i,
`ifdef ACC_MON_ARGMAX_EN
  input  logic [N_OUT*WIDTH-1:0]       act_in_i,
`endif
  input  logic                         clear_i,
  output logic                         busy_o,
  output logic                         correct_o,
  output logic                         correct_valid_o,
  output logic [$clog2(WINDOW+1)-1:0]  recent_o,
  output logic                         window_full_o,
  output logic [CNT_W-1:0]             total_correct_o,
  output logic [CNT_W-1:0]             num_cases_o,
  output logic [CNT_W-1:0]             epoch_o,
  output logic                         epoch_done_o,
  output logic [CNT_W-1:0]             epoch_correct_o,
  output logic                         done_o,
  output logic                         overrun_o
);

  localparam int unsigned PTR_W  = $clog2(WINDOW);
  localparam int unsigned RCNT_W = $clog2(WINDOW + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] EP_LAST  = CNT_W'(EPOCH_LEN - 1);

  // S_CLR: zero window buffer, one entry/cycle | S_RUN: accept cases | S_DONE: TOTAL reached, stats frozen
  typedef enum logic [1:0] {
    S_CLR  = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [WINDOW-1:0]   win_q;
  logic [RCNT_W-1:0]   recent_q;
  logic                window_full_q;
  logic                correct_q;
  logic                correct_valid_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    num_cases_q;
  logic [CNT_W-1:0]    epoch_q;
  logic                epoch_done_q;
  logic [CNT_W-1:0]    epoch_correct_q;
  logic [CNT_W-1:0]    ep_cnt_q;
  logic [CNT_W-1:0]    ep_idx_q;
  logic                done_q;
  logic                overrun_q;

  logic                case_c;
  logic                win_old;
  logic [PTR_W-1:0]    ptr_next;
  logic [RCNT_W-1:0]   recent_d;
  logic [CNT_W-1:0]    total_d;
  logic [CNT_W-1:0]    num_cases_d;
  logic [CNT_W-1:0]    ep_cnt_d;
  logic [CNT_W-1:0]    epoch_d;
  logic                unused_bits;

`ifdef ACC_MON_ARGMAX_EN
  localparam int unsigned IDX_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  logic [WIDTH-1:0]    best_val;
  logic [IDX_W-1:0]    best_idx;
  logic [IDX_W-1:0]    hot_idx;
  logic                hot_found;

  // strict '>' keeps the earliest neuron on ties; descending scan keeps the lowest hot bit
  always_comb begin
    best_val  = act_in_i[WIDTH-1:0];
    best_idx  = '0;
    hot_idx   = '0;
    hot_found = 1'b0;
    for (int i = 1; i < int'(N_CLASS); i++) begin
      if (act_in_i[WIDTH*i +: WIDTH] > best_val) begin
        best_val = act_in_i[WIDTH*i +: WIDTH];
        best_idx = IDX_W'(i);
      end
    end
    for (int i = int'(N_CLASS) - 1; i >= 0; i--) begin
      if (y_ideal_i[i]) begin
        hot_found = 1'b1;
        hot_idx   = IDX_W'(i);
      end
    end
    case_c = hot_found && (best_idx == hot_idx);
  end

  assign unused_bits = ^{a_out_i, act_in_i};
`else
  assign case_c      = (a_out_i[N_CLASS-1:0] == y_ideal_i[N_CLASS-1:0]);
  assign unused_bits = ^{a_out_i, y_ideal_i};
`endif

  always_comb begin
    win_old     = win_q[ptr_q];
    ptr_next    = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    recent_d    = recent_q - RCNT_W'(win_old) + RCNT_W'(case_c);
    num_cases_d = (num_cases_q == CNT_MAX) ? num_cases_q : num_cases_q + CNT_ONE;
    total_d     = (case_c && total_q != CNT_MAX) ? total_q + CNT_ONE : total_q;
    ep_cnt_d    = (case_c && ep_cnt_q != CNT_MAX) ? ep_cnt_q + CNT_ONE : ep_cnt_q;
    epoch_d     = (epoch_q == CNT_MAX) ? epoch_q : epoch_q + CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    correct_valid_q <= 1'b0;
    epoch_done_q    <= 1'b0;
    if (!reset_i || clear_i) begin
      state_q         <= S_CLR;
      // after reset one arming cycle passes before the sweep; a clear starts sweeping immediately
      busy_q          <= reset_i;
      ptr_q           <= '0;
      recent_q        <= '0;
      window_full_q   <= 1'b0;
      correct_q       <= 1'b0;
      total_q         <= '0;
      num_cases_q     <= '0;
      epoch_q         <= CNT_ONE;
      epoch_correct_q <= '0;
      ep_cnt_q        <= '0;
      ep_idx_q        <= '0;
      done_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLR: begin
          if (case_valid_i) overrun_q <= 1'b1;
          if (!busy_q) begin
            busy_q <= 1'b1;
          end else begin
            win_q[ptr_q] <= 1'b0;
            ptr_q        <= ptr_next;
            if (ptr_q == PTR_LAST) begin
              busy_q  <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (case_valid_i) begin
            win_q[ptr_q]    <= case_c;
            ptr_q           <= ptr_next;
            recent_q        <= recent_d;
            correct_q       <= case_c;
            correct_valid_q <= 1'b1;
            num_cases_q     <= num_cases_d;
            total_q         <= total_d;
            if (num_cases_d >= WIN_C) window_full_q <= 1'b1;
            if (ep_idx_q == EP_LAST) begin
              epoch_correct_q <= ep_cnt_d;
              ep_cnt_q        <= '0;
              ep_idx_q        <= '0;
              epoch_q         <= epoch_d;
              epoch_done_q    <= 1'b1;
            end else begin
              ep_cnt_q <= ep_cnt_d;
              ep_idx_q <= ep_idx_q + CNT_ONE;
            end
            if (num_cases_d >= TOTAL_C) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (case_valid_i) overrun_q <= 1'b1;
        end
        default: state_q <= S_CLR;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign correct_o       = correct_q;
  assign correct_valid_o = correct_valid_q;
  assign recent_o        = recent_q;
  assign window_full_o   = window_full_q;
  assign total_correct_o = total_q;
  assign num_cases_o     = num_cases_q;
  assign epoch_o         = epoch_q;
  assign epoch_done_o    = epoch_done_q;
  assign epoch_correct_o = epoch_correct_q;
  assign done_o          = done_q;
  assign overrun_o       = overrun_q;

endmodule
